button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes and debounces a raw pad, then emits
// press/release/long-press strobes and a wrapping press counter.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned LONG_PRESS_CYCLES = 16,
    parameter logic        ACTIVE_LOW_IN     = 1'b1
) (
    input  logic       FAB_CCC_GL0,
    input  logic       FAB_RESET_N,
    input  logic       BTN_IN,
    output logic       GPIO_8_F2M,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic       LONG_PULSE,
    output logic [7:0] PRESS_CNT
);

    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] HOLD_LAST = 24'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sync;
    logic        btn;
    logic [15:0] deb_cnt;
    logic [15:0] deb_nxt;
    logic [23:0] hold_cnt;
    logic        long_done;
    logic        press_evt;
    logic        release_evt;
    logic        long_evt;

    assign btn = sync[1] ^ ACTIVE_LOW_IN;

    always_comb begin
        state_nxt   = state;
        deb_nxt     = deb_cnt;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        case (state)
            IDLE: begin
                if (btn) begin
                    state_nxt = PRESS_WAIT;
                    deb_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn) begin
                    state_nxt = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    press_evt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 16'd1;
                end
            end
            PRESSED: begin
                if (!btn) begin
                    state_nxt = RELEASE_WAIT;
                    deb_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn) begin
                    state_nxt = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = IDLE;
                    release_evt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold timing follows the debounced level, so release bounces inside
    // RELEASE_WAIT neither pause nor restart it.
    always_comb begin
        long_evt = GPIO_8_F2M && !long_done && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge FAB_CCC_GL0) begin
        if (!FAB_RESET_N) begin
            sync          <= {2{ACTIVE_LOW_IN}};
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            GPIO_8_F2M    <= 1'b0;
            PRESS_PULSE   <= 1'b0;
            RELEASE_PULSE <= 1'b0;
            LONG_PULSE    <= 1'b0;
            PRESS_CNT     <= '0;
        end else begin
            sync          <= {sync[0], BTN_IN};
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            PRESS_PULSE   <= press_evt;
            RELEASE_PULSE <= release_evt;
            LONG_PULSE    <= long_evt;
            if (press_evt) begin
                GPIO_8_F2M <= 1'b1;
                PRESS_CNT  <= PRESS_CNT + 8'd1;
                hold_cnt   <= '0;
                long_done  <= 1'b0;
            end else begin
                if (release_evt) begin
                    GPIO_8_F2M <= 1'b0;
                end
                if (GPIO_8_F2M && !long_done) begin
                    hold_cnt <= hold_cnt + 24'd1;
                    if (long_evt) begin
                        long_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
